alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
- Age-ordered result queue directly downstream of the combinational ALU.
- Captures each valid ALU result (destination preg, data, branch mask) and holds it until the CDB arbiter grants a broadcast slot.
- Tracks branch resolution: on a mispredict it kills dependent entries; on a correct prediction it clears the resolved mask bit.
- Back-pressures the ALU issue slot when full.

Parameters:
DEPTH, 4, number of buffered results (>=2)
PREG_W, 6, physical register index width
DATA_W, 32, result width
BM_W, 4, branch mask width (one bit per in-flight branch)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low; buffer cleared when low at a rising edge
in_valid  in  1  ALU result valid this cycle
in_preg  in  PREG_W  destination physical register
in_result  in  DATA_W  ALU result data
in_bmask  in  BM_W  branch mask of the producing instruction
in_ready  out  1  buffer can accept a result this cycle
cdb_req  out  1  request CDB broadcast for the oldest entry
cdb_preg  out  PREG_W  preg of the oldest entry
cdb_result  out  DATA_W  data of the oldest entry
cdb_bmask  out  BM_W  mask of the oldest entry, with the resolved bit already cleared
cdb_gnt  in  1  arbiter grant; the oldest entry leaves at this clock edge
br_valid  in  1  branch resolved this cycle
br_mask_bit  in  BM_W  one-hot tag of the resolved branch
br_mispred  in  1  resolved branch mispredicted (qualified by br_valid)
count  out  $clog2(DEPTH+1)  number of valid entries (registered)

Behaviour:
- Storage: compacting shift queue; slot 0 is always the oldest entry. Each slot holds valid, preg, result, bmask.
- Reset (reset==0 at an edge): all valid bits clear and count=0. Outputs after reset: cdb_req=0, in_ready=1, count=0. cdb_preg, cdb_result and cdb_bmask are driven to 0 when slot 0 is invalid.
- kill(x) = br_valid & br_mispred & |(x.bmask & br_mask_bit).
- clr(x) = br_valid & ~br_mispred, which clears br_mask_bit in x.bmask.
- cdb_req = slot0.valid & ~kill(slot0). This is combinational from registered state and is gated the same cycle a mispredict hits it.
- cdb_bmask = slot0.bmask & ~(clr ? br_mask_bit : 0).
- in_ready = (count < DEPTH). It is registered-derived and does not credit a same-cycle grant.
- in_valid while in_ready==0 is illegal. The bench asserts on it; the RTL drops the input.
- Next-state computation at each edge, in this order:
  1. Remove slot 0 if cdb_req & cdb_gnt.
  2. Remove every remaining entry with kill(x).
  3. Apply clr to every survivor.
  4. If in_valid & in_ready & ~kill(in), append the incoming entry (with clr applied) after the survivors, preserving age order.
  5. Shift survivors toward slot 0 with no holes. count = number of survivors plus the appended entry.
- cdb_gnt while cdb_req==0 is ignored.
- Latency: a result accepted at edge N is visible on cdb_* from edge N onward (cdb_req high in cycle N+1) when the buffer was empty. There is no same-cycle bypass.
- Throughput: one accept and one grant per cycle, sustained. With a grant every cycle, count is stable.
- Simultaneous full + grant: in_ready is still 0 that cycle; space appears the next cycle.
- Mispredict with a zero-mask entry: the entry is unaffected.
- A mispredict killing all entries: count=0 next cycle.
- Reset mid-operation discards all entries, including one being granted that cycle. The arbiter must not rely on it.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> count=0, cdb_req=0, in_ready=1 after release.
- Single result: in preg=5, result=0x0000_00AA, bmask=0 at edge N; cdb_gnt=0 -> cdb_req=1 with preg=5/0xAA from cycle N+1 and held until cdb_gnt=1, then count=0.
- Fill/back-pressure: 4 accepts with no grant -> count=4, in_ready=0. Grant the oldest -> count=3, in_ready=1 next cycle, and the remaining entries stay in insertion order.
- Mispredict squash: entries with bmask 0001, 0010, 0001, 0000; br_valid=1, br_mask_bit=0001, br_mispred=1 -> count=2 next cycle, with the survivors in original order (0010 first).
- Correct resolve: same fill with br_mispred=0, mask bit 0010 -> all 4 kept. The second entry's bmask becomes 0000, and cdb_bmask reflects the clear in the same cycle.
- Simultaneous: head bmask=0100 with cdb_gnt=1 and mispredict on 0100 in the same cycle -> cdb_req=0 that cycle, entry removed, no broadcast. An incoming in_bmask=0100 the same cycle is not enqueued.

Source files
------------

// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if
//   Bundles the ALU-to-buffer result path, the CDB broadcast request/grant,
//   the branch-resolution broadcast and the occupancy count.
//   master: ALU / arbiter / branch-unit side (drives in_*, cdb_gnt, br_*).
//   slave : the result buffer (drives in_ready, cdb_req, cdb_*, count).
//   Signals:
//     in_valid/in_preg/in_result/in_bmask : incoming ALU result
//     in_ready                            : buffer can take a result
//     cdb_req/cdb_preg/cdb_result/cdb_bmask : oldest entry offered to CDB
//     cdb_gnt                             : oldest entry leaves this edge
//     br_valid/br_mask_bit/br_mispred     : branch resolution
//     count                               : registered occupancy
interface alu_result_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32,
  parameter int BM_W   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [PREG_W-1:0] in_preg;
  logic [DATA_W-1:0] in_result;
  logic [BM_W-1:0]   in_bmask;
  logic              in_ready;
  logic              cdb_req;
  logic [PREG_W-1:0] cdb_preg;
  logic [DATA_W-1:0] cdb_result;
  logic [BM_W-1:0]   cdb_bmask;
  logic              cdb_gnt;
  logic              br_valid;
  logic [BM_W-1:0]   br_mask_bit;
  logic              br_mispred;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_preg, in_result, in_bmask, cdb_gnt,
           br_valid, br_mask_bit, br_mispred,
    input  in_ready, cdb_req, cdb_preg, cdb_result, cdb_bmask, count
  );

  modport slave (
    input  in_valid, in_preg, in_result, in_bmask, cdb_gnt,
           br_valid, br_mask_bit, br_mispred,
    output in_ready, cdb_req, cdb_preg, cdb_result, cdb_bmask, count
  );
endinterface

// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   Age-ordered result queue behind the ALU. Holds each result until the CDB
//   arbiter grants it, squashes entries on a branch mispredict, clears the
//   resolved mask bit on a correct prediction and back-pressures the ALU when
//   full. Slot 0 is always the oldest entry; the queue is compacted every edge.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-low; empties the buffer
//     bus   : alu_result_buffer_if.slave (result in, CDB out, branch in, count)
module alu_result_buffer #(
  parameter int DEPTH  = 4,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32,
  parameter int BM_W   = 4
) (
  input logic               clock,
  input logic               reset,
  alu_result_buffer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              vld_q  [DEPTH];
  logic [PREG_W-1:0] preg_q [DEPTH];
  logic [DATA_W-1:0] res_q  [DEPTH];
  logic [BM_W-1:0]   bm_q   [DEPTH];
  logic [CNT_W-1:0]  count_q;

  logic              vld_d  [DEPTH];
  logic [PREG_W-1:0] preg_d [DEPTH];
  logic [DATA_W-1:0] res_d  [DEPTH];
  logic [BM_W-1:0]   bm_d   [DEPTH];
  logic [CNT_W-1:0]  count_d;

  logic [BM_W-1:0]   clr_mask;
  logic              grant;
  logic              accept;

  function automatic logic kill_f(input logic [BM_W-1:0] bm, input logic brv,
                                  input logic mis, input logic [BM_W-1:0] bbit);
    return brv & mis & (|(bm & bbit));
  endfunction

  assign clr_mask = (bus.br_valid & ~bus.br_mispred) ? bus.br_mask_bit : '0;

  // Head is offered to the CDB unless a mispredict kills it this very cycle.
  assign bus.cdb_req    = vld_q[0] & ~kill_f(bm_q[0], bus.br_valid, bus.br_mispred,
                                             bus.br_mask_bit);
  assign bus.cdb_preg   = vld_q[0] ? preg_q[0] : '0;
  assign bus.cdb_result = vld_q[0] ? res_q[0] : '0;
  assign bus.cdb_bmask  = vld_q[0] ? (bm_q[0] & ~clr_mask) : '0;
  // Fullness is judged on registered occupancy only; a same-cycle grant does
  // not open a slot until the next cycle.
  assign bus.in_ready   = (count_q < CNT_W'(DEPTH));
  assign bus.count      = count_q;

  assign grant  = bus.cdb_req & bus.cdb_gnt;
  assign accept = bus.in_valid & bus.in_ready &
                  ~kill_f(bus.in_bmask, bus.br_valid, bus.br_mispred, bus.br_mask_bit);

  // Compaction: survivors are written in age order to write pointer wp, then
  // the new entry lands right behind them. Constant-index inner loops keep
  // the write port a plain mux per slot.
  always_comb begin
    logic [CNT_W-1:0] wp;
    for (int j = 0; j < DEPTH; j++) begin
      vld_d[j]  = 1'b0;
      preg_d[j] = '0;
      res_d[j]  = '0;
      bm_d[j]   = '0;
    end
    wp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !(i == 0 && grant) &&
          !kill_f(bm_q[i], bus.br_valid, bus.br_mispred, bus.br_mask_bit)) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (CNT_W'(j) == wp) begin
            vld_d[j]  = 1'b1;
            preg_d[j] = preg_q[i];
            res_d[j]  = res_q[i];
            bm_d[j]   = bm_q[i] & ~clr_mask;
          end
        end
        wp = wp + CNT_W'(1);
      end
    end
    if (accept) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (CNT_W'(j) == wp) begin
          vld_d[j]  = 1'b1;
          preg_d[j] = bus.in_preg;
          res_d[j]  = bus.in_result;
          bm_d[j]   = bus.in_bmask & ~clr_mask;
        end
      end
      wp = wp + CNT_W'(1);
    end
    count_d = wp;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q   <= '{default: 1'b0};
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is qualified by vld_q everywhere it is used.
  always_ff @(posedge clock) begin
    preg_q <= preg_d;
    res_q  <= res_d;
    bm_q   <= bm_d;
  end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer
//   Directed scenarios followed by randomized traffic, all checked against a
//   queue-based reference model of the result buffer.
module tb_alu_result_buffer;
  localparam int DEPTH  = 4;
  localparam int PREG_W = 6;
  localparam int DATA_W = 32;
  localparam int BM_W   = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  alu_result_buffer_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W), .BM_W(BM_W)) bus ();

  alu_result_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W), .BM_W(BM_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
    logic [BM_W-1:0]   bm;
  } ent_t;

  ent_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic killm(input logic [BM_W-1:0] bm, input logic brv,
                                 input logic mis, input logic [BM_W-1:0] bbit);
    return brv && mis && ((bm & bbit) != '0);
  endfunction

  // Drive one cycle's inputs mid-low-phase and compare outputs to the model.
  task automatic drive(input logic rn, input logic iv, input logic [PREG_W-1:0] p,
                       input logic [DATA_W-1:0] d, input logic [BM_W-1:0] bm,
                       input logic gnt, input logic brv, input logic [BM_W-1:0] bbit,
                       input logic mis);
    logic [BM_W-1:0] cm;
    logic            ereq;
    @(negedge clock);
    reset           = rn;
    bus.in_valid    = iv;
    bus.in_preg     = p;
    bus.in_result   = d;
    bus.in_bmask    = bm;
    bus.cdb_gnt     = gnt;
    bus.br_valid    = brv;
    bus.br_mask_bit = bbit;
    bus.br_mispred  = mis;
    #1;
    if (rn) begin
      cm   = (brv && !mis) ? bbit : '0;
      ereq = (q.size() > 0) && !killm(q[0].bm, brv, mis, bbit);
      chk("cdb_req", bus.cdb_req, ereq);
      chk("in_ready", bus.in_ready, q.size() < DEPTH);
      chk("count", bus.count, q.size());
      chk("cdb_preg", bus.cdb_preg, (q.size() > 0) ? q[0].preg : '0);
      chk("cdb_result", bus.cdb_result, (q.size() > 0) ? q[0].data : '0);
      chk("cdb_bmask", bus.cdb_bmask, (q.size() > 0) ? (q[0].bm & ~cm) : '0);
      if (iv) chk("illegal_in", bus.in_ready, 1'b1);
    end
  endtask

  // Advance the model across the rising edge using the inputs now applied.
  task automatic tick();
    logic [BM_W-1:0] cm;
    logic            brv, mis, ereq, ok_in;
    logic [BM_W-1:0] bbit;
    ent_t            nq[$];
    brv  = bus.br_valid;
    mis  = bus.br_mispred;
    bbit = bus.br_mask_bit;
    cm   = (brv && !mis) ? bbit : '0;
    ereq = (q.size() > 0) && !killm(q[0].bm, brv, mis, bbit);
    ok_in = bus.in_valid && (q.size() < DEPTH) && !killm(bus.in_bmask, brv, mis, bbit);
    @(posedge clock);
    if (!reset) begin
      q.delete();
    end else begin
      if (ereq && bus.cdb_gnt) void'(q.pop_front());
      foreach (q[i])
        if (!killm(q[i].bm, brv, mis, bbit))
          nq.push_back('{preg: q[i].preg, data: q[i].data, bm: q[i].bm & ~cm});
      if (ok_in)
        nq.push_back('{preg: bus.in_preg, data: bus.in_result, bm: bus.in_bmask & ~cm});
      q = nq;
    end
  endtask

  task automatic idle(input logic gnt);
    drive(1'b1, 1'b0, '0, '0, '0, gnt, 1'b0, '0, 1'b0);
  endtask

  task automatic push(input logic [PREG_W-1:0] p, input logic [DATA_W-1:0] d,
                      input logic [BM_W-1:0] bm);
    drive(1'b1, 1'b1, p, d, bm, 1'b0, 1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) begin
      idle(1'b1);
      tick();
    end
  endtask

  task automatic fill_squash_set();
    push(6'd10, 32'h10, 4'b0001);
    push(6'd11, 32'h11, 4'b0010);
    push(6'd12, 32'h12, 4'b0001);
    push(6'd13, 32'h13, 4'b0000);
  endtask

  initial begin
    // Reset held two cycles with in_valid asserted.
    drive(1'b0, 1'b1, 6'd1, 32'h1, '0, 1'b0, 1'b0, '0, 1'b0); tick();
    drive(1'b0, 1'b1, 6'd2, 32'h2, '0, 1'b0, 1'b0, '0, 1'b0); tick();
    idle(1'b0);
    chk("rst_count", bus.count, 0);
    chk("rst_req", bus.cdb_req, 0);
    chk("rst_ready", bus.in_ready, 1);
    tick();

    // Single result held until granted.
    push(6'd5, 32'h0000_00AA, 4'b0000);
    idle(1'b0);
    chk("single_req", bus.cdb_req, 1);
    chk("single_preg", bus.cdb_preg, 5);
    chk("single_data", bus.cdb_result, 32'hAA);
    tick();
    idle(1'b0); tick();
    idle(1'b1); tick();
    idle(1'b0);
    chk("single_cnt", bus.count, 0);
    tick();

    // Fill, back-pressure, then grant the head.
    for (int i = 0; i < DEPTH; i++) push(PREG_W'(20 + i), DATA_W'(100 + i), '0);
    idle(1'b0);
    chk("full_cnt", bus.count, 4);
    chk("full_ready", bus.in_ready, 0);
    tick();
    idle(1'b1); tick();
    idle(1'b0);
    chk("after_gnt_cnt", bus.count, 3);
    chk("after_gnt_ready", bus.in_ready, 1);
    chk("after_gnt_head", bus.cdb_preg, 21);
    tick();
    drain();

    // Mispredict squash on mask bit 0001.
    fill_squash_set();
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 4'b0001, 1'b1);
    chk("squash_req", bus.cdb_req, 0);
    tick();
    idle(1'b0);
    chk("squash_cnt", bus.count, 2);
    chk("squash_head", bus.cdb_preg, 11);
    chk("squash_bm", bus.cdb_bmask, 4'b0010);
    tick();
    idle(1'b1); tick();
    idle(1'b0);
    chk("squash_second", bus.cdb_preg, 13);
    tick();
    drain();

    // Correct resolve on mask bit 0010.
    fill_squash_set();
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 4'b0010, 1'b0);
    tick();
    idle(1'b0);
    chk("resolve_cnt", bus.count, 4);
    tick();
    idle(1'b1); tick();
    idle(1'b0);
    chk("resolve_head", bus.cdb_preg, 11);
    chk("resolve_bm", bus.cdb_bmask, 4'b0000);
    tick();
    drain();
    push(6'd40, 32'h40, 4'b0010);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 4'b0010, 1'b0);
    chk("resolve_same", bus.cdb_bmask, 4'b0000);
    tick();
    drain();

    // Grant and mispredict collide on the head; same-tag input is dropped.
    push(6'd30, 32'h30, 4'b0100);
    drive(1'b1, 1'b1, 6'd31, 32'h31, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1);
    chk("collide_req", bus.cdb_req, 0);
    tick();
    idle(1'b0);
    chk("collide_cnt", bus.count, 0);
    tick();

    // Zero-mask entry survives a mispredict.
    push(6'd33, 32'h33, 4'b0000);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 4'b1000, 1'b1);
    tick();
    idle(1'b0);
    chk("zero_mask_cnt", bus.count, 1);
    tick();

    // Reset mid-operation with a grant pending.
    push(6'd34, 32'h34, 4'b0000);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0); tick();
    idle(1'b0);
    chk("midrst_cnt", bus.count, 0);
    chk("midrst_req", bus.cdb_req, 0);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic rn, iv, brv;
      rn  = ($urandom_range(0, 199) != 0);
      iv  = (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      brv = ($urandom_range(0, 3) == 0);
      drive(rn, iv, PREG_W'($urandom), DATA_W'($urandom), BM_W'($urandom),
            1'($urandom), brv, BM_W'(1 << $urandom_range(0, BM_W - 1)), 1'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
